// File: rtl/eth_frame_generator_if.sv
// TX stream bundle between the Ethernet frame generator and its consumer.
// The generator takes the master view; the PCS/encoder or bench takes the slave view.
interface eth_frame_generator_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
  logic                  i_start;
  logic [7:0]            i_interrupt;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic [CTRL_WIDTH-1:0] o_tx_ctrl;

  modport master (
    input  i_start,
    input  i_interrupt,
    output o_tx_data,
    output o_tx_ctrl
  );

  modport slave (
    output i_start,
    output i_interrupt,
    input  o_tx_data,
    input  o_tx_ctrl
  );
endinterface

// File: rtl/eth_frame_generator.sv
// 64-bit XGMII-style Ethernet TX frame generator.
// Emits start/preamble/SFD, header, incrementing payload, CRC-32 FCS, terminate and
// inter-frame idles, with an interrupt code for error injection, stop and abort.
module eth_frame_generator #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0011_2233_4455,
  parameter logic [15:0] ETH_TYPE    = 16'h0800,
  parameter int unsigned PAYLOAD_LEN = 46,
  parameter int unsigned IFG_WORDS   = 1
) (
  input logic                   clk,
  input logic                   i_rst,
  eth_frame_generator_if.master tx
);

  localparam int unsigned FrameBytes = PAYLOAD_LEN + 18;
  localparam int unsigned NumWords   = FrameBytes / CTRL_WIDTH;
  localparam int unsigned HdrBytes   = 14;
  localparam int unsigned FcsBytes   = 4;

  localparam logic [15:0] LastWord = 16'(NumWords - 1);
  localparam logic [15:0] LastIfg  = 16'(IFG_WORDS - 1);

  localparam logic [111:0] Header = {DST_MAC, SRC_MAC, ETH_TYPE};

  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

  localparam logic [7:0] IntError = 8'h01;
  localparam logic [7:0] IntStop  = 8'h02;
  localparam logic [7:0] IntAbort = 8'h03;

  localparam logic [DATA_WIDTH-1:0] WordIdle  = {CTRL_WIDTH{8'h07}};
  localparam logic [DATA_WIDTH-1:0] WordPre   = {8'hD5, {(CTRL_WIDTH - 2){8'h55}}, 8'hFB};
  localparam logic [DATA_WIDTH-1:0] WordTerm  = {{(CTRL_WIDTH - 1){8'h07}}, 8'hFD};
  localparam logic [DATA_WIDTH-1:0] WordError = {CTRL_WIDTH{8'hFE}};

  localparam logic [CTRL_WIDTH-1:0] CtrlAll  = '1;
  localparam logic [CTRL_WIDTH-1:0] CtrlNone = '0;
  localparam logic [CTRL_WIDTH-1:0] CtrlPre  = CtrlNone | 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StTerm,
    StIfg
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [31:0]           crc_q, crc_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           ifg_cnt_q, ifg_cnt_d;

  logic [DATA_WIDTH-1:0] frame_word;
  logic [31:0]           crc_full;
  logic [31:0]           crc_last;
  logic                  last_word;
  logic                  may_start;

  // Byte idx of the frame body (header followed by payload, FCS excluded).
  function automatic logic [7:0] stream_byte(input logic [15:0] idx);
    if (idx < 16'(HdrBytes)) begin
      return 8'(Header >> (8 * (HdrBytes - 1 - 32'(idx))));
    end
    return 8'(idx - 16'(HdrBytes));
  endfunction

  // Reflected CRC-32 over the first nbytes lanes of data, lane 0 first.
  function automatic logic [31:0] crc_update(input logic [31:0]           crc_in,
                                             input logic [DATA_WIDTH-1:0] data,
                                             input int unsigned           nbytes);
    logic [31:0] crc;
    crc = crc_in;
    for (int unsigned b = 0; b < CTRL_WIDTH; b++) begin
      if (b < nbytes) begin
        crc = crc ^ {24'h0, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          crc = crc[0] ? ((crc >> 1) ^ CrcPoly) : (crc >> 1);
        end
      end
    end
    return crc;
  endfunction

  // Raw body word for the current word index, its CRC contributions and the FCS merge.
  always_comb begin
    frame_word = '0;
    for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
      frame_word[8*i +: 8] = stream_byte(word_cnt_q * 16'(CTRL_WIDTH) + 16'(i));
    end
    last_word = (word_cnt_q == LastWord);
    crc_full  = crc_update(crc_q, frame_word, CTRL_WIDTH);
    crc_last  = crc_update(crc_q, frame_word, CTRL_WIDTH - FcsBytes);
    // FCS occupies the top four lanes of the final word, LSB in the lower lane.
    if (last_word) begin
      frame_word[DATA_WIDTH-1 -: 32] = ~crc_last;
    end
  end

  assign may_start = tx.i_start && (tx.i_interrupt != IntStop);

  // Next-state, next-output and counter/CRC updates for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    data_d     = WordIdle;
    ctrl_d     = CtrlAll;
    crc_d      = crc_q;
    word_cnt_d = word_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (may_start) begin
          state_d = StPreamble;
        end
      end

      StPreamble: begin
        crc_d      = CrcInit;
        word_cnt_d = '0;
        if (tx.i_interrupt == IntAbort) begin
          data_d    = WordTerm;
          ifg_cnt_d = '0;
          state_d   = StIfg;
        end else begin
          data_d  = WordPre;
          ctrl_d  = CtrlPre;
          state_d = StData;
        end
      end

      StData: begin
        if (tx.i_interrupt == IntAbort) begin
          // Truncate: terminate in place of this word, no FCS.
          data_d     = WordTerm;
          crc_d      = CrcInit;
          word_cnt_d = '0;
          ifg_cnt_d  = '0;
          state_d    = StIfg;
        end else begin
          // An injected error replaces the lanes on the wire only; CRC sees the real bytes.
          if (tx.i_interrupt == IntError) begin
            data_d = WordError;
            ctrl_d = CtrlAll;
          end else begin
            data_d = frame_word;
            ctrl_d = CtrlNone;
          end
          if (last_word) begin
            crc_d      = CrcInit;
            word_cnt_d = '0;
            state_d    = StTerm;
          end else begin
            crc_d      = crc_full;
            word_cnt_d = word_cnt_q + 16'd1;
          end
        end
      end

      StTerm: begin
        data_d    = WordTerm;
        ifg_cnt_d = '0;
        state_d   = StIfg;
      end

      StIfg: begin
        if (ifg_cnt_q == LastIfg) begin
          ifg_cnt_d = '0;
          state_d   = may_start ? StPreamble : StIdle;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, registered outputs, CRC and counters; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      data_q     <= WordIdle;
      ctrl_q     <= CtrlAll;
      crc_q      <= CrcInit;
      word_cnt_q <= '0;
      ifg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      crc_q      <= crc_d;
      word_cnt_q <= word_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
    end
  end

  assign tx.o_tx_data = data_q;
  assign tx.o_tx_ctrl = ctrl_q;

endmodule

// File: tb/tb_eth_frame_generator.sv
// Self-checking bench for eth_frame_generator: a frame-template model predicts every
// output word, and directed checks pin the template and key timing points.
module tb_eth_frame_generator;

  localparam int NumWords = (46 + 18) / 8;
  localparam int IfgWords = 1;
  localparam int FrameLen = 1 + NumWords + 1 + IfgWords;

  localparam logic [71:0] WIdle = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] WPre  = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] WTerm = {8'hFF, 64'h07070707070707FD};
  localparam logic [71:0] WErr  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  eth_frame_generator_if #(.DATA_WIDTH(64)) tx_if ();

  eth_frame_generator #(
    .DATA_WIDTH (64),
    .CTRL_WIDTH (8),
    .DST_MAC    (48'hFFFF_FFFF_FFFF),
    .SRC_MAC    (48'h0011_2233_4455),
    .ETH_TYPE   (16'h0800),
    .PAYLOAD_LEN(46),
    .IFG_WORDS  (IfgWords)
  ) dut (
    .clk  (clk),
    .i_rst(rst),
    .tx   (tx_if)
  );

  logic [71:0] dut_w;
  assign dut_w = {tx_if.o_tx_ctrl, tx_if.o_tx_data};

  logic [71:0] tmpl [FrameLen];
  logic [71:0] exp_w;
  int          mdl_idx = -1;
  logic        chk_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Bitwise CRC-32 (IEEE 802.3), data bits LSB first.
  function automatic logic [31:0] crc32_sw(input logic [7:0] bytes [$]);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFF_FFFF;
    foreach (bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ bytes[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB8_8320;
      end
    end
    return ~crc;
  endfunction

  // Model: position within the frame template, advanced on each clock edge.
  always @(posedge clk) begin : model
    int          n;
    logic [71:0] e;
    n = mdl_idx;
    if (!rst) begin
      e = WIdle;
      n = -1;
    end else if (n < 0) begin
      e = WIdle;
      if (tx_if.i_start && tx_if.i_interrupt != 8'h02) n = 0;
    end else if (tx_if.i_interrupt == 8'h03 && n <= NumWords) begin
      e = WTerm;
      n = NumWords + 2;
    end else begin
      e = tmpl[n];
      if (tx_if.i_interrupt == 8'h01 && n >= 1 && n <= NumWords) e = WErr;
      n++;
      if (n == FrameLen) n = (tx_if.i_start && tx_if.i_interrupt != 8'h02) ? 0 : -1;
    end
    mdl_idx <= n;
    exp_w   <= e;
  end

  // Compare DUT against the model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) check("stream", dut_w, exp_w);
  end

  task automatic sync_preamble(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (dut_w === WPre) found = 1'b1;
    end
    check(name, {71'h0, found}, 72'h1);
  endtask

  initial begin : main
    logic [7:0]  fb [$];
    logic [7:0]  pin [$];
    string       s;
    logic [47:0] mac;
    logic [15:0] et;
    logic [31:0] fcs;
    logic [63:0] d;
    int          last_pre;
    int          n_pre;

    // Build the expected frame from the header fields, payload rule and CRC.
    mac = 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 6; i++) begin fb.push_back(mac[47:40]); mac = mac << 8; end
    mac = 48'h0011_2233_4455;
    for (int i = 0; i < 6; i++) begin fb.push_back(mac[47:40]); mac = mac << 8; end
    et = 16'h0800;
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int k = 0; k < 46; k++) fb.push_back(8'(k));
    fcs = crc32_sw(fb);
    fb.push_back(fcs[7:0]);
    fb.push_back(fcs[15:8]);
    fb.push_back(fcs[23:16]);
    fb.push_back(fcs[31:24]);
    tmpl[0] = WPre;
    for (int w = 0; w < NumWords; w++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = fb[8*w + i];
      tmpl[1 + w] = {8'h00, d};
    end
    tmpl[NumWords + 1] = WTerm;
    for (int i = NumWords + 2; i < FrameLen; i++) tmpl[i] = WIdle;

    // Pin the model itself.
    s = "123456789";
    for (int i = 0; i < s.len(); i++) pin.push_back(s[i]);
    check("crc_model_pin", {40'h0, crc32_sw(pin)}, {40'h0, 32'hCBF43926});
    check("tmpl_word0", tmpl[1], {8'h00, 64'h1100FFFFFFFFFFFF});
    check("tmpl_word1", tmpl[2], {8'h00, 64'h0100000855443322});
    check("tmpl_last_payload", {40'h0, tmpl[NumWords][31:0]}, {40'h0, 32'h2D2C2B2A});

    rst               = 1'b0;
    tx_if.i_start     = 1'b0;
    tx_if.i_interrupt = 8'h00;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_idle", dut_w, WIdle);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start", dut_w, WIdle);

    // First frame with default parameters.
    tx_if.i_start = 1'b1;
    @(negedge clk); check("start_latency", dut_w, WIdle);
    @(negedge clk); check("preamble", dut_w, WPre);
    @(negedge clk); check("data_word0", dut_w, {8'h00, 64'h1100FFFFFFFFFFFF});
    @(negedge clk); check("data_word1", dut_w, {8'h00, 64'h0100000855443322});
    repeat (6) @(negedge clk);
    check("last_word_payload", {40'h0, dut_w[71:64], dut_w[31:0]}, {40'h0, 8'h00, 32'h2D2C2B2A});
    @(negedge clk); check("term", dut_w, WTerm);
    @(negedge clk); check("ifg_idle", dut_w, WIdle);
    @(negedge clk); check("next_preamble", dut_w, WPre);

    // Continuous start for 1000 ns: preambles every 11 cycles.
    last_pre = -1;
    n_pre    = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dut_w === WPre) begin
        if (last_pre >= 0) check("preamble_spacing", 72'(c - last_pre), 72'd11);
        last_pre = c;
        n_pre++;
      end
    end
    check("preamble_count", 72'(n_pre), 72'd9);

    // Stop mid-frame: frame finishes, then idles until the code clears.
    tx_if.i_interrupt = 8'h02;
    repeat (40) @(negedge clk);
    check("stop_idle", dut_w, WIdle);
    tx_if.i_interrupt = 8'h00;
    @(negedge clk); check("resume_latency", dut_w, WIdle);
    @(negedge clk); check("resume_preamble", dut_w, WPre);

    // Abort pulsed while the third data word is on the outputs.
    repeat (3) @(negedge clk);
    tx_if.i_interrupt = 8'h03;
    @(negedge clk); check("abort_term", dut_w, WTerm);
    tx_if.i_interrupt = 8'h00;
    @(negedge clk); check("abort_ifg", dut_w, WIdle);
    @(negedge clk); check("abort_preamble", dut_w, WPre);
    @(negedge clk); check("abort_word0", dut_w, {8'h00, 64'h1100FFFFFFFFFFFF});

    // Error inject for one data word; FCS of this frame must be unchanged.
    tx_if.i_interrupt = 8'h01;
    @(negedge clk); check("error_word", dut_w, WErr);
    tx_if.i_interrupt = 8'h00;

    // Reset during the fifth data word.
    sync_preamble("sync_before_reset");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); check("reset_midframe", dut_w, WIdle);
    rst = 1'b1;
    @(negedge clk); check("release_latency", dut_w, WIdle);
    @(negedge clk); check("release_preamble", dut_w, WPre);

    // Drop start mid-frame: frame completes, then idle.
    repeat (3) @(negedge clk);
    tx_if.i_start = 1'b0;
    repeat (20) @(negedge clk);
    check("start_drop_idle", dut_w, WIdle);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_frame_generator.md
# eth_frame_generator

64-bit Ethernet TX frame generator for the MII/BASE-R verification environment. When started, it emits complete, back-to-back Ethernet frames as XGMII-style 64-bit data/control words: start + preamble + SFD, header, incrementing payload, IEEE 802.3 CRC-32, terminate, and inter-frame idles. It drives the TX side of the PCS/encoder under test. A small interrupt code lets the bench inject errors, abort frames, or hold transmission.

## Interface
- DATA_WIDTH, 64: data bus width; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8: control bus width, one bit per byte lane.
- DST_MAC, 48'hFFFF_FFFF_FFFF: destination MAC; bits [47:40] are sent first.
- SRC_MAC, 48'h0011_2233_4455: source MAC; bits [47:40] are sent first.
- ETH_TYPE, 16'h0800: EtherType; bits [15:8] are sent first.
- PAYLOAD_LEN, 46: payload bytes; must be ≥46 with (PAYLOAD_LEN+18) a multiple of 8.
- IFG_WORDS, 1: all-idle words inserted after the terminate word (≥1).
- clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  one clock; reset is synchronous and active-low.
- i_start  in  1  level; while high, frames are generated continuously.
- i_interrupt  in  8  interrupt code (see Operation).
- o_tx_data  out  DATA_WIDTH  TX data; lane i = bits [8i+7:8i], lane 0 is first on the wire.
- o_tx_ctrl  out  CTRL_WIDTH  bit i = 1 means lane i is a control character.

## Operation
- Control characters: IDLE 0x07, START 0xFB (lane 0 only), TERMINATE 0xFD, ERROR 0xFE.
- States: IDLE → PREAMBLE → DATA → TERM → IFG → (PREAMBLE if i_start, else IDLE).
- IDLE state:
  - Outputs data 64'h0707070707070707, ctrl 8'hFF.
  - Moves to PREAMBLE when i_start = 1 and i_interrupt ≠ 8'h02.
- PREAMBLE: data 64'hD5555555555555FB, ctrl 8'h01.
- DATA: byte stream DST_MAC, SRC_MAC, ETH_TYPE, payload, FCS.
  - Byte stream is packed 8 bytes per word, ctrl 8'h00.
  - Payload byte k = k[7:0].
  - Word count = (PAYLOAD_LEN+18)/8.
- FCS is CRC-32 over DST..payload.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Sent least-significant byte first in the last 4 lanes of the last DATA word.
  - The CRC is updated over 8 bytes per cycle.
- TERM: data 64'h07070707070707FD, ctrl 8'hFF.
- IFG: IFG_WORDS all-idle words, then re-evaluates i_start and i_interrupt.
- i_start deasserted mid-frame: the current frame completes normally (through IFG), then the block goes to IDLE.
- i_interrupt codes (sampled every cycle):
  - 8'h00: normal operation.
  - 8'h01, error inject: in DATA, the current output word becomes all 0xFE with ctrl 8'hFF. The frame continues, the word counter advances, and the CRC still includes the original bytes.
  - 8'h02, stop: no new frame starts; the current frame completes. The block stays in IDLE while the code is asserted.
  - 8'h03, abort: in PREAMBLE or DATA, the next word is TERM (no FCS), followed by IFG. The CRC is reset.
  - Any other value behaves as 8'h00.

## Timing
- Outputs are registered.
- i_start sampled high in IDLE at edge N → PREAMBLE word on the outputs after edge N+1's update, i.e. one cycle of latency.
- Default frame occupies 11 cycles: 1 preamble, 8 data, 1 term, 1 IFG.
- Continuous i_start gives a new preamble every 11 cycles.
- Reset (i_rst = 0 at a rising edge):
  - Outputs go to 64'h0707070707070707 / 8'hFF, state goes to IDLE, CRC goes to 0xFFFFFFFF, counters clear.
  - Reset takes priority over all inputs, including mid-frame. No terminate is emitted for the truncated frame.
- No output is X or Z after the first reset edge.

## Test plan
- Reset held, then i_start = 0 → outputs constant 64'h0707070707070707 / 8'hFF.
- i_start = 1 with defaults:
  - 64'hD5555555555555FB/01, then 64'h1100FFFFFFFFFFFF/00, then 64'h0100000855443322/00.
  - Then six further data words, the last ending in the FCS, which must match a software CRC-32 model.
  - Then 64'h07070707070707FD/FF, then one idle word, then the next preamble.
- i_start held 1000 ns → frames repeat every 11 cycles, all identical including FCS.
- i_interrupt = 8'h02 mid-frame → that frame completes with a correct FCS, then idles persist until 8'h00 is restored.
- i_interrupt = 8'h03 pulsed during the third data word → next word is 64'h07070707070707FD/FF, then IFG, then a new full frame.
- i_rst driven low during the fifth data word → the next output is idle/FF. After release with i_start = 1, a fresh preamble follows one cycle later.
